hebb_trainer: RTL and testbench
===============================

// Module: hebb_trainer
// PURPOSE
// - Writer side of the 25-neuron Hopfield weight table that the recall engine reads.
// - Accepts 25-bit training patterns one at a time and accumulates Hebbian weights
//   with a sequential read-modify-write: w[k*25+m] += (p[k]==p[m]) ? +1 : -1.
// - Provides a synchronous read port so the recall engine can fetch signed weights.
// PARAMETERS
// - N        25   neurons per pattern; the table holds NSQ=N*N entries
// - W        4    signed weight width; weights saturate to [-(2^(W-1)), 2^(W-1)-1]
// - MAX_PAT  4    patterns accepted before the next clear
// PORTS
// - clk        in   1            single clock; everything is on the rising edge
// - rst        in   1            asynchronous reset, active-low
// - clear_req  in   1            request to zero the table and set pat_count=0
// - pat_valid  in   1            pattern offered
// - pat        in   N            pattern; bit index = neuron index
// - pat_ready  out  1            pattern accepted when pat_valid & pat_ready
// - busy       out  1            high in CLEAR and ACCUM
// - done       out  1            one-cycle pulse at the end of CLEAR or ACCUM
// - pat_count  out  clog2(MAX_PAT+1)  patterns stored since the last clear
// - sat        out  1            sticky flag; set when any update clamps
// - rd_addr    in   clog2(NSQ)   weight address k*N+m
// - rd_data    out  W (signed)   weight at rd_addr, valid 1 cycle after rd_addr
// BEHAVIOUR
// - Reset values: state=CLEAR, busy=1, pat_ready=0, done=0, pat_count=0, sat=0, rd_data=0.
// - Table contents are not reset. The forced CLEAR zeroes the table.
// - FSM states: CLEAR -> IDLE -> ACCUM -> IDLE.
// - CLEAR
//   - Writes 0 to addr 0..NSQ-1, one entry per cycle.
//   - After writing addr NSQ-1: done=1 for one cycle, pat_count=0, sat=0, then IDLE.
// - IDLE
//   - pat_ready = (pat_count < MAX_PAT).
//   - If clear_req=1, go to CLEAR; clear_req beats pat_valid when both are high.
//   - Otherwise, on pat_valid & pat_ready: latch pat and go to ACCUM.
// - ACCUM
//   - Address counter 0..NSQ-1, with k = addr / N and m = addr % N held as separate
//     wrap counters (no divider).
//   - Two-stage read-modify-write: read addr i while writing addr i-1.
//   - Acceptance edge E0: done is high in the cycle after edge E0+NSQ+1.
//   - pat_count increments in the same cycle as done.
//   - Update arithmetic is done in W+1 bits, then clamped to W bits; any clamp sets sat.
// - pat_ready=0 outside IDLE, and whenever pat_count==MAX_PAT.
//   A further pattern stalls until clear_req.
// - clear_req in ACCUM aborts the pattern: it is not counted and the FSM goes to CLEAR.
//   clear_req in CLEAR is ignored.
// - rd port is independent. During ACCUM it returns the current content, which may be
//   partially updated; the reader gates on busy.
// - Asserting rst mid-operation aborts everything; after release the block re-runs CLEAR.
// CONFIGURATION
// - HEBB_ZERO_DIAG_EN defined: entries with k==m are always written 0
//   (classic Hopfield, no self-feedback).
// - Not defined: the diagonal accumulates like every other entry
//   (+1 per pattern, clamped).
// STRUCTURE
// - Package hebb_pkg: N, NSQ, W, weight_t (signed W), state_t enum {CLEAR, IDLE, ACCUM},
//   and saturation limits WMAX/WMIN.
// - Sub-module hebb_weight_ram: NSQ x W storage with 1 write port and 2 synchronous
//   read ports (internal RMW port and external rd port); it has no reset.
// TESTING
// - Reset release -> busy=1 for NSQ cycles, done pulse, pat_ready=1; every rd_addr reads 0.
// - Train D=25'b0111010010100101001001111 -> done at the stated latency,
//   rd[1]=+1, rd[4]=-1, pat_count=1.
// - Train D,C=25'b0011101001010000100011111,J=25'b1111000001000010000111110,
//   M=25'b1000110001101011101110001 -> rd[27]=+4, rd[1]=0, rd[0]=+4
//   (0 with HEBB_ZERO_DIAG_EN), pat_count=4, pat_ready=0.
// - Offer a 5th pattern with MAX_PAT=4 -> pat_ready stays 0 and the table is unchanged;
//   clear_req -> CLEAR, then reads are 0 and pat_count=0.
// - clear_req 100 cycles into ACCUM -> pattern not counted, CLEAR runs, all reads 0;
//   clear_req and pat_valid together in IDLE -> CLEAR wins.
// - MAX_PAT=10, the same pattern 9 times -> rd[0] clamps at +7 and sat=1;
//   rst pulse mid-ACCUM -> CLEAR re-runs and sat=0.

Source files
------------

// File: rtl/hebb_pkg.sv
// hebb_pkg: shared sizes, weight type, FSM states and saturation limits for the Hebbian trainer
package hebb_pkg;
    localparam int N   = 25;
    localparam int NSQ = N * N;
    localparam int W   = 4;
    localparam int AW  = $clog2(NSQ);
    localparam int KW  = $clog2(N);
    typedef logic signed [W-1:0] weight_t;
    typedef enum logic [1:0] {CLEAR, IDLE, ACCUM} state_t;
    localparam weight_t WMAX = weight_t'(2 ** (W - 1) - 1);
    localparam weight_t WMIN = weight_t'(-(2 ** (W - 1)));
endpackage

// File: rtl/hebb_weight_ram.sv
// hebb_weight_ram: NSQ x W weight store, one write port, two synchronous read ports, no reset
module hebb_weight_ram
    import hebb_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [W-1:0]  i_wd,
    input  logic [AW-1:0] i_ra,
    output logic [W-1:0]  o_qa,
    input  logic [AW-1:0] i_rb,
    output logic [W-1:0]  o_qb
);
    logic [W-1:0] r_mem [NSQ];
    logic [W-1:0] r_qa, r_qb;
    assign o_qa = r_qa;
    assign o_qb = r_qb;
    // write port plus two registered reads (RMW port a, external port b)
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_wa] <= i_wd;
        r_qa <= r_mem[i_ra];
        r_qb <= r_mem[i_rb];
    end
endmodule

// File: rtl/hebb_trainer.sv
// hebb_trainer: accumulates Hebbian weights for 25-neuron patterns; define HEBB_ZERO_DIAG_EN to keep the diagonal at zero
module hebb_trainer
    import hebb_pkg::*;
#(
    parameter int MAX_PAT = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear_req,
    input  logic                         i_pat_valid,
    input  logic [N-1:0]                 i_pat,
    output logic                         o_pat_ready,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(MAX_PAT+1)-1:0] o_pat_count,
    output logic                         o_sat,
    input  logic [AW-1:0]                i_rd_addr,
    output logic [W-1:0]                 o_rd_data
);
    localparam int PCW = $clog2(MAX_PAT + 1);
    state_t         r_state, w_state_nxt;
    logic [AW-1:0]  r_addr, r_wr_addr, w_wa;
    logic [KW-1:0]  r_k, r_m;
    logic [N-1:0]   r_pat;
    logic [PCW-1:0] r_pat_count;
    logic           r_rd_act, r_wr_en, r_eq, r_diag, r_done, r_sat, r_rd_vld;
    logic           w_accept, w_go_clr, w_clr_last, w_acc_last, w_step, w_we, w_ovf, w_clip;
    logic [W-1:0]   w_qa, w_qb, w_wd, w_upd, w_sat_val;
    logic [W:0]     w_sum;

    assign o_pat_ready = r_state == IDLE && r_pat_count < PCW'(MAX_PAT);
    assign o_busy      = r_state != IDLE;
    assign o_done      = r_done;
    assign o_pat_count = r_pat_count;
    assign o_sat       = r_sat;
    assign o_rd_data   = r_rd_vld ? w_qb : '0;

    assign w_go_clr   = i_clear_req && r_state != CLEAR;
    assign w_accept   = r_state == IDLE && !i_clear_req && i_pat_valid && o_pat_ready;
    assign w_clr_last = r_state == CLEAR && r_addr == AW'(NSQ - 1);
    assign w_acc_last = r_state == ACCUM && !i_clear_req && r_wr_en && r_wr_addr == AW'(NSQ - 1);
    assign w_step     = r_state == CLEAR || (r_state == ACCUM && r_rd_act);

    // Sign-extend the old weight, add +/-1 in W+1 bits, clamp on overflow.
    assign w_sum     = {w_qa[W-1], w_qa} + (r_eq ? (W+1)'(1) : {(W+1){1'b1}});
    assign w_ovf     = w_sum[W] ^ w_sum[W-1];
    assign w_sat_val = w_ovf ? (w_sum[W] ? WMIN : WMAX) : w_sum[W-1:0];
`ifdef HEBB_ZERO_DIAG_EN
    assign w_upd  = r_diag ? '0 : w_sat_val;
    assign w_clip = !r_diag && w_ovf;
`else
    assign w_upd  = w_sat_val;
    assign w_clip = w_ovf;
`endif

    assign w_we = r_state == CLEAR || (r_state == ACCUM && r_wr_en);
    assign w_wa = r_state == CLEAR ? r_addr : r_wr_addr;
    assign w_wd = r_state == CLEAR ? '0 : w_upd;

    hebb_weight_ram u_ram (
        .i_clk (i_clk),
        .i_we  (w_we),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .i_ra  (r_addr),
        .o_qa  (w_qa),
        .i_rb  (i_rd_addr),
        .o_qb  (w_qb)
    );

    // next-state logic: clear_req wins in IDLE and aborts ACCUM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   w_state_nxt = w_clr_last ? IDLE : CLEAR;
            IDLE:    w_state_nxt = i_clear_req ? CLEAR : w_accept ? ACCUM : IDLE;
            ACCUM:   w_state_nxt = i_clear_req ? CLEAR : w_acc_last ? IDLE : ACCUM;
            default: w_state_nxt = CLEAR;
        endcase
    end

    // state register; reset forces a full table clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= CLEAR;
        else          r_state <= w_state_nxt;
    end

    // address/k/m counters, RMW pipeline, pattern count and sticky saturation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr      <= '0;
            r_k         <= '0;
            r_m         <= '0;
            r_pat       <= '0;
            r_rd_act    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_eq        <= 1'b0;
            r_diag      <= 1'b0;
            r_done      <= 1'b0;
            r_pat_count <= '0;
            r_sat       <= 1'b0;
            r_rd_vld    <= 1'b0;
        end else begin
            r_rd_vld <= 1'b1;
            r_done   <= w_clr_last || w_acc_last;
            if (w_go_clr || w_accept) begin
                r_addr <= '0;
                r_k    <= '0;
                r_m    <= '0;
            end else if (w_step) begin
                r_addr <= r_addr + AW'(1);
                r_m    <= r_m == KW'(N - 1) ? '0 : r_m + KW'(1);
                r_k    <= r_m == KW'(N - 1) ? r_k + KW'(1) : r_k;
            end
            if (w_accept) r_pat <= i_pat;
            r_rd_act  <= w_accept || (r_rd_act && !w_go_clr && r_addr != AW'(NSQ - 1));
            r_wr_en   <= r_state == ACCUM && r_rd_act && !i_clear_req;
            r_wr_addr <= r_addr;
            r_eq      <= r_pat[r_k] == r_pat[r_m];
            r_diag    <= r_k == r_m;
            if (w_clr_last) r_pat_count <= '0;
            else if (w_acc_last) r_pat_count <= r_pat_count + PCW'(1);
            if (w_clr_last) r_sat <= 1'b0;
            else if (r_state == ACCUM && r_wr_en && w_clip) r_sat <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hebb_trainer.sv
// tb_hebb_trainer: randomized self-checking bench with a behavioural weight-table model
module tb_hebb_trainer;
    localparam int N   = 25;
    localparam int NSQ = 625;
    localparam logic [24:0] PD = 25'b0111010010100101001001111;
    localparam logic [24:0] PC = 25'b0011101001010000100011111;
    localparam logic [24:0] PJ = 25'b1111000001000010000111110;
    localparam logic [24:0] PM = 25'b1000110001101011101110001;

    logic        clk = 1'b0;
    logic        rst_n[2], clear_req[2], pat_valid[2];
    logic [24:0] pat[2];
    logic [9:0]  rd_addr[2];
    logic        pat_ready[2], busy[2], done[2], sat[2];
    logic [3:0]  rd_data[2];
    logic [2:0]  pc0;
    logic [3:0]  pc1;
    int          total = 0, bad = 0;
    int          mw[2][NSQ];
    int          mpc[2], msat[2];
    int          mmax[2] = '{4, 10};

    always #5 clk = ~clk;

    hebb_trainer #(.MAX_PAT(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_clear_req(clear_req[0]), .i_pat_valid(pat_valid[0]),
        .i_pat(pat[0]), .o_pat_ready(pat_ready[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_pat_count(pc0), .o_sat(sat[0]), .i_rd_addr(rd_addr[0]), .o_rd_data(rd_data[0])
    );

    hebb_trainer #(.MAX_PAT(10)) u_dut10 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_clear_req(clear_req[1]), .i_pat_valid(pat_valid[1]),
        .i_pat(pat[1]), .o_pat_ready(pat_ready[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_pat_count(pc1), .o_sat(sat[1]), .i_rd_addr(rd_addr[1]), .o_rd_data(rd_data[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pcv(input int d);
        return d == 1 ? int'(pc1) : int'(pc0);
    endfunction

    task automatic m_clear(input int d);
        for (int a = 0; a < NSQ; a++) mw[d][a] = 0;
        mpc[d]  = 0;
        msat[d] = 0;
    endtask

    task automatic m_train(input int d, input logic [24:0] p);
        for (int k = 0; k < N; k++)
            for (int m = 0; m < N; m++) begin
                int v;
`ifdef HEBB_ZERO_DIAG_EN
                if (k == m) begin
                    mw[d][k*N+m] = 0;
                    continue;
                end
`endif
                v = mw[d][k*N+m] + ((p[k] == p[m]) ? 1 : -1);
                if (v > 7)  begin v = 7;  msat[d] = 1; end
                if (v < -8) begin v = -8; msat[d] = 1; end
                mw[d][k*N+m] = v;
            end
        mpc[d]++;
    endtask

    task automatic rd(input int d, input int a, output int v);
        rd_addr[d] = 10'(a);
        @(negedge clk);
        v = int'($signed(rd_data[d]));
    endtask

    task automatic dump(input int d, input string tag);
        int v;
        for (int a = 0; a < NSQ; a++) begin
            rd(d, a, v);
            chk($sformatf("%s[%0d]", tag, a), v, mw[d][a]);
        end
    endtask

    task automatic wait_clear(input int d);
        int cnt = 0;
        while (busy[d] && cnt < 3000) begin
            cnt++;
            @(negedge clk);
        end
        chk("clr_len", cnt, NSQ);
        chk("clr_done", done[d], 1);
        chk("clr_ready", pat_ready[d], 1);
        chk("clr_pc", pcv(d), 0);
        chk("clr_sat", sat[d], 0);
    endtask

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy[d], 1);
        chk("rst_ready", pat_ready[d], 0);
        chk("rst_done", done[d], 0);
        chk("rst_pc", pcv(d), 0);
        chk("rst_sat", sat[d], 0);
        chk("rst_rd", int'(rd_data[d]), 0);
        rst_n[d] = 1'b1;
        m_clear(d);
        wait_clear(d);
    endtask

    task automatic pulse_clear(input int d);
        clear_req[d] = 1'b1;
        @(negedge clk);
        clear_req[d] = 1'b0;
        chk("clrq_busy", busy[d], 1);
        m_clear(d);
        wait_clear(d);
    endtask

    task automatic train(input int d, input logic [24:0] p);
        int j = 0;
        while (!pat_ready[d] && j < 20) begin
            @(negedge clk);
            j++;
        end
        chk("tr_ready", pat_ready[d], 1);
        pat[d] = p;
        pat_valid[d] = 1'b1;
        @(negedge clk);
        pat_valid[d] = 1'b0;
        chk("tr_busy", busy[d], 1);
        j = 0;
        while (!done[d] && j < 3000) begin
            @(negedge clk);
            j++;
        end
        chk("tr_lat", j, NSQ + 1);
        m_train(d, p);
        chk("tr_pc", pcv(d), mpc[d]);
        chk("tr_sat", sat[d], msat[d]);
        chk("tr_rdy_after", pat_ready[d], mpc[d] < mmax[d] ? 1 : 0);
    endtask

    initial begin
        int v, nb;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; clear_req[d] = 1'b0; pat_valid[d] = 1'b0;
            pat[d] = '0; rd_addr[d] = '0;
        end
        do_reset(0);
        @(negedge clk);
        chk("done_pulse", done[0], 0);
        dump(0, "init");
        train(0, PD);
        rd(0, 1, v);  chk("D_rd1", v, 1);
        rd(0, 4, v);  chk("D_rd4", v, -1);
        train(0, PC);
        train(0, PJ);
        train(0, PM);
        rd(0, 27, v); chk("rd27", v, 4);
        rd(0, 1, v);  chk("rd1", v, 0);
        rd(0, 0, v);
`ifdef HEBB_ZERO_DIAG_EN
        chk("rd0", v, 0);
`else
        chk("rd0", v, 4);
`endif
        chk("pc4", pcv(0), 4);
        chk("ready4", pat_ready[0], 0);
        dump(0, "four");
        pat[0] = 25'($urandom);
        pat_valid[0] = 1'b1;
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            nb += int'(busy[0]);
        end
        pat_valid[0] = 1'b0;
        chk("stall_busy", nb, 0);
        chk("stall_ready", pat_ready[0], 0);
        chk("stall_pc", pcv(0), 4);
        dump(0, "stall");
        pulse_clear(0);
        dump(0, "clr");
        train(0, 25'($urandom));
        train(0, 25'($urandom));
        dump(0, "rnd");
        pat[0] = 25'($urandom);
        pat_valid[0] = 1'b1;
        @(negedge clk);
        pat_valid[0] = 1'b0;
        repeat (99) @(negedge clk);
        chk("abort_busy", busy[0], 1);
        pulse_clear(0);
        dump(0, "abort");
        train(0, 25'($urandom));
        clear_req[0] = 1'b1;
        pat_valid[0] = 1'b1;
        pat[0] = 25'($urandom);
        @(negedge clk);
        clear_req[0] = 1'b0;
        pat_valid[0] = 1'b0;
        chk("both_busy", busy[0], 1);
        m_clear(0);
        wait_clear(0);
        rd(0, 1, v);  chk("both_rd1", v, 0);
        rd(0, 0, v);  chk("both_rd0", v, 0);
        do_reset(1);
        repeat (9) train(1, PD);
        rd(1, 0, v);
`ifdef HEBB_ZERO_DIAG_EN
        chk("sat_rd0", v, 0);
`else
        chk("sat_rd0", v, 7);
`endif
        chk("sat_flag", sat[1], 1);
        chk("sat_pc", pcv(1), 9);
        dump(1, "sat");
        pat[1] = 25'($urandom);
        pat_valid[1] = 1'b1;
        @(negedge clk);
        pat_valid[1] = 1'b0;
        repeat (50) @(negedge clk);
        do_reset(1);
        dump(1, "rstclr");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
